// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer: routes single CPU read/write requests either to a
// memory controller (addresses below 16'hC000) or to an I/O peripheral
// (16'hC000 and above). Memory accesses hold one enable for a fixed number
// of cycles followed by a one-cycle recovery gap. I/O accesses hold a strobe
// until io_ack arrives or a timeout expires. Every access ends with a
// one-cycle cpu_ready pulse. All outputs are registered.
module mem_bus_sequencer #(
  parameter int unsigned ENABLE_CYCLES = 3,
  parameter int unsigned IO_TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        bus_error,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data_in,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [15:0] mem_data_out,
  output logic [13:0] io_addr,
  output logic [15:0] io_wdata,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [15:0] io_rdata,
  input  logic        io_ack
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    MEM_ACCESS  = 3'd1,
    MEM_RECOVER = 3'd2,
    IO_ACCESS   = 3'd3,
    DONE        = 3'd4
  } state_t;

  localparam logic [3:0]  EN_LAST = 4'(ENABLE_CYCLES);
  localparam logic [7:0]  IO_LAST = 8'(IO_TIMEOUT);
  localparam logic [15:0] IO_BASE = 16'hC000;

  state_t      state_r;
  logic [15:0] addr_r;
  logic [15:0] wdata_r;
  logic        we_r;
  logic [3:0]  mem_cnt_r;
  logic [7:0]  io_cnt_r;

  // Sequencer FSM: request capture, bus strobes, completion and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      addr_r       <= 16'h0000;
      wdata_r      <= 16'h0000;
      we_r         <= 1'b0;
      mem_cnt_r    <= 4'd0;
      io_cnt_r     <= 8'd0;
      cpu_rdata    <= 16'h0000;
      cpu_ready    <= 1'b0;
      bus_error    <= 1'b0;
      mem_address  <= 16'h0000;
      mem_data_in  <= 16'h0000;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      io_addr      <= 14'h0000;
      io_wdata     <= 16'h0000;
      io_rd        <= 1'b0;
      io_wr        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cpu_ready <= 1'b0;
          bus_error <= 1'b0;
          if (cpu_req) begin
            addr_r  <= cpu_addr;
            wdata_r <= cpu_wdata;
            we_r    <= cpu_we;
            if (cpu_addr < IO_BASE) begin
              state_r <= MEM_ACCESS;
            end else begin
              state_r <= IO_ACCESS;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        MEM_ACCESS: begin
          mem_address <= addr_r;
          mem_data_in <= wdata_r;
          // The counter tracks enable cycles already issued; once the full
          // burst has been held, drop both enables for the recovery cycle.
          if (mem_cnt_r == EN_LAST) begin
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            mem_cnt_r    <= 4'd0;
            state_r      <= MEM_RECOVER;
          end else begin
            mem_read_en  <= ~we_r;
            mem_write_en <= we_r;
            mem_cnt_r    <= mem_cnt_r + 4'd1;
          end
        end

        MEM_RECOVER: begin
          // Read data is taken at the end of the gap cycle.
          if (!we_r) begin
            cpu_rdata <= mem_data_out;
          end else begin
            cpu_rdata <= cpu_rdata;
          end
          cpu_ready <= 1'b1;
          bus_error <= 1'b0;
          state_r   <= DONE;
        end

        IO_ACCESS: begin
          io_addr  <= addr_r[13:0];
          io_wdata <= wdata_r;
          if (!(io_rd || io_wr)) begin
            // First cycle: raise the strobe; io_ack is only honoured once it is up.
            io_rd    <= ~we_r;
            io_wr    <= we_r;
            io_cnt_r <= 8'd1;
          end else if (io_ack) begin
            // Acknowledge wins even on the cycle the timeout would fire.
            io_rd     <= 1'b0;
            io_wr     <= 1'b0;
            io_cnt_r  <= 8'd0;
            if (!we_r) begin
              cpu_rdata <= io_rdata;
            end else begin
              cpu_rdata <= cpu_rdata;
            end
            cpu_ready <= 1'b1;
            bus_error <= 1'b0;
            state_r   <= DONE;
          end else if (io_cnt_r == IO_LAST) begin
            io_rd     <= 1'b0;
            io_wr     <= 1'b0;
            io_cnt_r  <= 8'd0;
            if (!we_r) begin
              cpu_rdata <= 16'hFFFF;
            end else begin
              cpu_rdata <= cpu_rdata;
            end
            cpu_ready <= 1'b1;
            bus_error <= 1'b1;
            state_r   <= DONE;
          end else begin
            io_cnt_r <= io_cnt_r + 8'd1;
          end
        end

        DONE: begin
          // cpu_req is ignored here so a held request waits for the next IDLE cycle.
          cpu_ready    <= 1'b0;
          bus_error    <= 1'b0;
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          io_rd        <= 1'b0;
          io_wr        <= 1'b0;
          state_r      <= IDLE;
        end

        default: begin
          state_r      <= IDLE;
          mem_cnt_r    <= 4'd0;
          io_cnt_r     <= 8'd0;
          cpu_ready    <= 1'b0;
          bus_error    <= 1'b0;
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          io_rd        <= 1'b0;
          io_wr        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed testbench for mem_bus_sequencer with hand-computed expectations.
module tb_mem_bus_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        bus_error;
  logic [15:0] mem_address;
  logic [15:0] mem_data_in;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [15:0] mem_data_out;
  logic [13:0] io_addr;
  logic [15:0] io_wdata;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_rdata;
  logic        io_ack;

  int n_vec;
  int n_err;

  // Per-access observations
  int          lat;
  int          rd_cnt;
  int          wr_cnt;
  int          ior_cnt;
  int          iow_cnt;
  int          both_cnt;
  logic        pre_en;
  logic [15:0] rd_at;
  logic        be_at;
  logic        ready_after;
  logic [15:0] seen_maddr;
  logic [15:0] seen_mdin;
  logic [13:0] seen_ioaddr;

  mem_bus_sequencer #(.ENABLE_CYCLES(3), .IO_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .bus_error    (bus_error),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .io_addr      (io_addr),
    .io_wdata     (io_wdata),
    .io_rd        (io_rd),
    .io_wr        (io_wr),
    .io_rdata     (io_rdata),
    .io_ack       (io_ack)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_strobes"}, 32'({cpu_ready, bus_error, mem_read_en, mem_write_en, io_rd, io_wr}), 32'h0);
    check_val({tag, "_rdata"},  32'(cpu_rdata),   32'h0);
    check_val({tag, "_maddr"},  32'(mem_address), 32'h0);
    check_val({tag, "_mdin"},   32'(mem_data_in), 32'h0);
    check_val({tag, "_ioaddr"}, 32'(io_addr),     32'h0);
    check_val({tag, "_iowd"},   32'(io_wdata),    32'h0);
  endtask

  // Issue one request (called just after a rising edge) and observe it to completion.
  task automatic run_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input int ack_after, input logic hold,
                            input logic [15:0] next_addr, input logic next_we);
    logic last_en;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    lat = -1; rd_cnt = 0; wr_cnt = 0; ior_cnt = 0; iow_cnt = 0; both_cnt = 0;
    pre_en = 1'bx; last_en = 1'b0; rd_at = 16'hxxxx; be_at = 1'bx;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (mem_read_en && mem_write_en) both_cnt++;
      if (io_rd && io_wr) both_cnt++;
      if (mem_read_en) rd_cnt++;
      if (mem_write_en) wr_cnt++;
      if (io_rd) ior_cnt++;
      if (io_wr) iow_cnt++;
      if (mem_read_en || mem_write_en) begin
        seen_maddr = mem_address;
        seen_mdin  = mem_data_in;
      end
      if (io_rd || io_wr) seen_ioaddr = io_addr;
      io_ack = (ack_after > 0) && ((ior_cnt + iow_cnt) == ack_after) && (io_rd || io_wr);
      if (cpu_ready) begin
        lat    = c;
        rd_at  = cpu_rdata;
        be_at  = bus_error;
        pre_en = last_en;
        io_ack = 1'b0;
        if (hold) begin
          cpu_addr = next_addr;
          cpu_we   = next_we;
        end else begin
          cpu_req = 1'b0;
        end
      end
      last_en = mem_read_en || mem_write_en;
    end
    @(posedge clk); #1;
    ready_after = cpu_ready;
  endtask

  initial begin
    logic any_ready;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    mem_data_out = 16'h0; io_rdata = 16'h0; io_ack = 1'b0;
    seen_maddr = 16'h0; seen_mdin = 16'h0; seen_ioaddr = 14'h0;

    #12;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Memory read
    mem_data_out = 16'hBEEF;
    run_access(1'b0, 16'h1234, 16'h0000, 0, 1'b0, 16'h0, 1'b0);
    check_val("mrd_lat",    32'(lat), 32'd5);
    check_val("mrd_rdcnt",  32'(rd_cnt), 32'd3);
    check_val("mrd_wrcnt",  32'(wr_cnt), 32'd0);
    check_val("mrd_gap",    32'(pre_en), 32'd0);
    check_val("mrd_addr",   32'(seen_maddr), 32'h1234);
    check_val("mrd_rdata",  32'(rd_at), 32'hBEEF);
    check_val("mrd_berr",   32'(be_at), 32'd0);
    check_val("mrd_pulse",  32'(ready_after), 32'd0);

    // Memory write at top of memory range
    mem_data_out = 16'h7777;
    run_access(1'b1, 16'hBFFF, 16'h5A5A, 0, 1'b0, 16'h0, 1'b0);
    check_val("mwr_lat",    32'(lat), 32'd5);
    check_val("mwr_wrcnt",  32'(wr_cnt), 32'd3);
    check_val("mwr_rdcnt",  32'(rd_cnt), 32'd0);
    check_val("mwr_iowr",   32'(iow_cnt + ior_cnt), 32'd0);
    check_val("mwr_mdin",   32'(seen_mdin), 32'h5A5A);
    check_val("mwr_rdata",  32'(rd_at), 32'hBEEF);

    // I/O read, ack in the 4th strobe cycle
    io_rdata = 16'h00A5;
    run_access(1'b0, 16'hC010, 16'h0000, 4, 1'b0, 16'h0, 1'b0);
    check_val("iord_lat",   32'(lat), 32'd5);
    check_val("iord_ioaddr",32'(seen_ioaddr), 32'h0010);
    check_val("iord_rdata", 32'(rd_at), 32'h00A5);
    check_val("iord_berr",  32'(be_at), 32'd0);
    check_val("iord_memen", 32'(rd_cnt + wr_cnt), 32'd0);

    // I/O timeout
    io_rdata = 16'h1234;
    run_access(1'b0, 16'hFFFF, 16'h0000, 0, 1'b0, 16'h0, 1'b0);
    check_val("tmo_lat",    32'(lat), 32'd16);
    check_val("tmo_rdcnt",  32'(ior_cnt), 32'd15);
    check_val("tmo_berr",   32'(be_at), 32'd1);
    check_val("tmo_rdata",  32'(rd_at), 32'hFFFF);
    check_val("tmo_pulse",  32'(ready_after), 32'd0);
    check_val("tmo_berr_after", 32'(bus_error), 32'd0);

    // Ack on the same cycle the timeout would fire: success wins
    io_rdata = 16'h1357;
    run_access(1'b0, 16'hC123, 16'h0000, 15, 1'b0, 16'h0, 1'b0);
    check_val("ackto_lat",  32'(lat), 32'd16);
    check_val("ackto_berr", 32'(be_at), 32'd0);
    check_val("ackto_rdata",32'(rd_at), 32'h1357);

    // I/O write with ack after 2 cycles; rdata must stay
    run_access(1'b1, 16'hD002, 16'h6666, 2, 1'b0, 16'h0, 1'b0);
    check_val("iowr_lat",   32'(lat), 32'd3);
    check_val("iowr_wrcnt", 32'(iow_cnt), 32'd2);
    check_val("iowr_rdcnt", 32'(ior_cnt), 32'd0);
    check_val("iowr_rdata", 32'(rd_at), 32'h1357);

    // Back-to-back with cpu_req held: 16'hBFFF to memory, then 16'hC000 to I/O
    mem_data_out = 16'h1111;
    io_rdata     = 16'h2222;
    run_access(1'b0, 16'hBFFF, 16'h0000, 0, 1'b1, 16'hC000, 1'b0);
    check_val("b2b1_lat",   32'(lat), 32'd5);
    check_val("b2b1_rdcnt", 32'(rd_cnt), 32'd3);
    check_val("b2b1_io",    32'(ior_cnt + iow_cnt), 32'd0);
    check_val("b2b1_rdata", 32'(rd_at), 32'h1111);
    run_access(1'b0, 16'hC000, 16'h0000, 2, 1'b0, 16'h0, 1'b0);
    check_val("b2b2_lat",   32'(lat), 32'd3);
    check_val("b2b2_iocnt", 32'(ior_cnt), 32'd2);
    check_val("b2b2_mem",   32'(rd_cnt + wr_cnt), 32'd0);
    check_val("b2b2_ioaddr",32'(seen_ioaddr), 32'h0000);
    check_val("b2b2_rdata", 32'(rd_at), 32'h2222);
    check_val("both_high",  32'(both_cnt), 32'd0);

    // Async reset during the second enable cycle of a memory read
    mem_data_out = 16'h9999;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042; cpu_wdata = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("arst_pre_en", 32'(mem_read_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_en_drop", 32'(mem_read_en), 32'd0);
    check_zero("arst");
    cpu_req = 1'b0;
    any_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      any_ready = any_ready | cpu_ready;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      any_ready = any_ready | cpu_ready | mem_read_en;
    end
    check_val("arst_no_ready", 32'(any_ready), 32'd0);

    // Recovery after reset
    mem_data_out = 16'hCAFE;
    run_access(1'b0, 16'h0001, 16'h0000, 0, 1'b0, 16'h0, 1'b0);
    check_val("post_lat",   32'(lat), 32'd5);
    check_val("post_rdata", 32'(rd_at), 32'hCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_sequencer.md
MEM_BUS_SEQUENCER -- requirements
Module: mem_bus_sequencer

Interface
REQ-001 The block SHALL have parameter ENABLE_CYCLES, default 3, giving the cycles mem_read_en/mem_write_en are held per access (legal 2..15).
REQ-002 The block SHALL have parameter IO_TIMEOUT, default 15, giving the maximum cycles waited for io_ack (legal 1..255).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port cpu_req, input, 1, CPU request; held high until cpu_ready.
REQ-006 The block SHALL have port cpu_we, input, 1, 1 = write, 0 = read; valid with cpu_req.
REQ-007 The block SHALL have port cpu_addr, input, 16, CPU word address.
REQ-008 The block SHALL have port cpu_wdata, input, 16, CPU write data.
REQ-009 The block SHALL have port cpu_rdata, output, 16, read result; valid while cpu_ready = 1.
REQ-010 The block SHALL have port cpu_ready, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port bus_error, output, 1, one-cycle pulse coincident with cpu_ready on I/O timeout.
REQ-012 The block SHALL have ports mem_address (output, 16), mem_data_in (output, 16), mem_read_en (output, 1), mem_write_en (output, 1) and mem_data_out (input, 16), forming the memory controller side.
REQ-013 The block SHALL have ports io_addr (output, 14), io_wdata (output, 16), io_rd (output, 1), io_wr (output, 1), io_rdata (input, 16) and io_ack (input, 1), forming the I/O peripheral side.

Function
REQ-014 The FSM SHALL have the states IDLE, MEM_ACCESS, MEM_RECOVER, IO_ACCESS and DONE; all outputs SHALL be registered.
REQ-015 In IDLE with cpu_req = 1, the block SHALL latch cpu_addr, cpu_wdata and cpu_we on that edge.
REQ-016 On that edge the FSM SHALL go to MEM_ACCESS if cpu_addr < 16'hC000, else to IO_ACCESS.
REQ-017 cpu_req SHALL be ignored in every state other than IDLE; latched values SHALL NOT change mid-access.
REQ-018 In MEM_ACCESS the block SHALL drive mem_address and mem_data_in from the latched values.
REQ-019 In MEM_ACCESS the block SHALL assert exactly one of mem_read_en or mem_write_en for exactly ENABLE_CYCLES consecutive cycles, using a 4-bit counter.
REQ-020 The FSM SHALL then enter MEM_RECOVER for exactly 1 cycle with both enables low, which resets the downstream byte phase.
REQ-021 On a read, the block SHALL capture mem_data_out into cpu_rdata at the end of MEM_RECOVER.
REQ-022 In IO_ACCESS the block SHALL drive io_addr = latched addr[13:0] and io_wdata from the latched data, and hold io_rd or io_wr high until io_ack = 1 or IO_TIMEOUT cycles elapse (8-bit counter).
REQ-023 An io_ack on the same cycle as the timeout SHALL take priority: success, no bus_error.
REQ-024 When io_ack = 1 on a read, the block SHALL latch io_rdata into cpu_rdata.
REQ-025 On I/O timeout, the block SHALL set cpu_rdata = 16'hFFFF for reads and pulse bus_error in DONE.
REQ-026 In DONE the block SHALL assert cpu_ready for 1 cycle, with all enables, io_rd and io_wr low, then return to IDLE unconditionally.
REQ-027 Read latency, counted as accepting edge to cpu_ready high, SHALL be ENABLE_CYCLES + 2 cycles for memory and N + 1 cycles for I/O, where N is the io_ack cycle count.
REQ-028 Back-to-back requests SHALL be separated by at least 1 IDLE cycle; a cpu_req still high in DONE SHALL be accepted only in the following IDLE cycle.
REQ-029 mem_read_en and mem_write_en SHALL never be high simultaneously; io_rd and io_wr SHALL never be high simultaneously.
REQ-030 Write completions SHALL leave cpu_rdata unchanged.

Reset
REQ-031 On rst_n = 0 the block SHALL immediately, without waiting for clk, go to IDLE, clear both counters, and clear all outputs: cpu_rdata = 0, cpu_ready = 0, bus_error = 0, mem_address = 0, mem_data_in = 0, mem_read_en = 0, mem_write_en = 0, io_addr = 0, io_wdata = 0, io_rd = 0, io_wr = 0.
REQ-032 Reset asserted mid-access SHALL abort the access without issuing cpu_ready; the first request after rst_n rises SHALL be accepted no earlier than the first rising edge after deassertion.

Verification
REQ-033 Memory read: cpu_req, addr 16'h1234, with mem_data_out = 16'hBEEF -> mem_read_en high for exactly 3 cycles, 1 low cycle, cpu_ready at latency 5 with cpu_rdata = 16'hBEEF.
REQ-034 Memory write: addr 16'hBFFF, cpu_wdata = 16'h5A5A -> mem_write_en high for 3 cycles, mem_data_in = 16'h5A5A, io_wr never high, cpu_rdata unchanged.
REQ-035 I/O read: addr 16'hC010 with io_ack after 4 cycles and io_rdata = 16'h00A5 -> io_addr = 14'h0010, cpu_rdata = 16'h00A5, bus_error = 0.
REQ-036 I/O timeout: addr 16'hFFFF, io_ack never asserted -> io_rd high for 15 cycles, then cpu_ready with bus_error = 1 and cpu_rdata = 16'hFFFF.
REQ-037 Boundary and back-to-back: cpu_req held high across two requests at 16'hBFFF then 16'hC000 -> first routed to memory, second to I/O, with 1 IDLE cycle between them.
REQ-038 Async reset: rst_n pulled low during the second enable cycle of a memory read -> mem_read_en drops before the next clk edge, no cpu_ready, and all outputs are 0.
